// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result SRAM drain path.
// Saturating build option: RESULT_DRAIN_SAT_EN.
package result_drain_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam int DEF_ADDRESSSIZE    = 10;
  localparam int DEF_PARTIAL_SUM_BW = 24;
  localparam int DEF_MATRIX_SIZE    = 64;
  localparam int DEF_LANES_PER_BEAT = 8;
  localparam int SAT_BITS           = 8;

  function automatic int beats_per_row(input int ms, input int lpb);
    return ms / lpb;
  endfunction

  function automatic int lane_lsb(input int idx, input int bw);
    return idx * bw;
  endfunction

  localparam int BEATS_PER_ROW =
    beats_per_row(DEF_MATRIX_SIZE, DEF_LANES_PER_BEAT);

endpackage

// File: rtl/result_drain_lane_sat.sv
// Per-lane signed saturator to the SAT_BITS range, sign-extended back.
// Built only when RESULT_DRAIN_SAT_EN is defined.
`ifdef RESULT_DRAIN_SAT_EN
module result_lane_sat
  import result_drain_pkg::*;
#(
  parameter int W = DEF_PARTIAL_SUM_BW
) (
  input  logic [W-1:0] i_lane,
  output logic [W-1:0] o_lane
);

  localparam int SMAX = (1 << (SAT_BITS - 1)) - 1;
  localparam int SMIN = -(1 << (SAT_BITS - 1));
  localparam logic [W-1:0] W_MAX = W'(SMAX);
  localparam logic [W-1:0] W_MIN = W'(SMIN);

  logic signed [W-1:0] w_in;

  assign w_in = $signed(i_lane);

  always_comb begin
    o_lane = i_lane;
    if (w_in > $signed(W_MAX))
      o_lane = W_MAX;
    else if (w_in < $signed(W_MIN))
      o_lane = W_MIN;
  end

endmodule
`endif

// File: rtl/result_drain.sv
// Walks a row range of the result SRAM and streams rows out as beats.
// Define RESULT_DRAIN_SAT_EN to saturate each lane to signed 8 bits.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int LANES_PER_BEAT = DEF_LANES_PER_BEAT
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [ADDRESSSIZE:0]                  row_count,
  output logic                                  sram_rd_en,
  output logic [ADDRESSSIZE-1:0]                sram_rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] m_data,
  output logic                                  m_row_last,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int BPR    = beats_per_row(MATRIX_SIZE, LANES_PER_BEAT);
  localparam int BEAT_W = PARTIAL_SUM_BW * LANES_PER_BEAT;
  localparam int ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int BCW    = (BPR > 1) ? $clog2(BPR) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [ADDRESSSIZE:0]   r_count;
  logic [ADDRESSSIZE:0]   r_row;
  logic [BCW-1:0]         r_beat;
  logic [ROW_W-1:0]       r_buf;

  logic                   w_hs;
  logic                   w_beat_last;
  logic                   w_last_row;
  logic [BEAT_W-1:0]      w_beats [BPR];
  logic [BEAT_W-1:0]      w_raw;
  logic [BEAT_W-1:0]      w_out;

  assign w_hs        = m_valid & m_ready;
  assign w_beat_last = (r_beat == BCW'(BPR - 1));
  assign w_last_row  = (r_row == r_count - 1'b1);

  always_ff @(posedge clk) begin
    if (!rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (start)
          w_next = (row_count == '0) ? S_DONE : S_READ;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:
        if (w_hs && w_beat_last)
          w_next = w_last_row ? S_DONE : S_READ;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // All outputs decode from registered state; m_ready never reaches m_valid.
  always_comb begin
    sram_rd_en   = (r_state == S_READ);
    sram_rd_addr = r_addr;
    m_valid      = (r_state == S_SEND);
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    m_data       = m_valid ? w_out : '0;
    m_row_last   = m_valid & w_beat_last;
    m_last       = m_valid & w_beat_last & w_last_row;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_count <= '0;
      r_row   <= '0;
      r_beat  <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (start) begin
            r_addr  <= base_addr;
            r_count <= row_count;
            r_row   <= '0;
            r_beat  <= '0;
          end
        S_CAPTURE: r_buf <= sram_rd_data;
        S_SEND:
          if (w_hs) begin
            if (w_beat_last) begin
              r_beat <= '0;
              r_row  <= r_row + 1'b1;
              r_addr <= r_addr + 1'b1;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < BPR; b++) begin : g_beat
    assign w_beats[b] = r_buf[lane_lsb(b, BEAT_W) +: BEAT_W];
  end

  assign w_raw = w_beats[r_beat];

  for (genvar l = 0; l < LANES_PER_BEAT; l++) begin : g_lane
`ifdef RESULT_DRAIN_SAT_EN
    result_lane_sat #(
      .W(PARTIAL_SUM_BW)
    ) u_sat (
      .i_lane(w_raw[lane_lsb(l, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW]),
      .o_lane(w_out[lane_lsb(l, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW])
    );
`else
    assign w_out[lane_lsb(l, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW] =
      w_raw[lane_lsb(l, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW];
`endif
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain with a behavioural SRAM.
// Saturation expectations follow RESULT_DRAIN_SAT_EN.
module tb_result_drain;

  localparam int AW     = 10;
  localparam int PSB    = 24;
  localparam int MS     = 64;
  localparam int LPB    = 8;
  localparam int BEAT_W = PSB * LPB;
  localparam int ROW_W  = PSB * MS;
  localparam int SATROW = 500;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       row_count = '0;
  logic              sram_rd_en;
  logic [AW-1:0]     sram_rd_addr;
  logic [ROW_W-1:0]  sram_rd_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [BEAT_W-1:0] m_data;
  logic              m_row_last;
  logic              m_last;
  logic              busy;
  logic              done;

  int n_pass = 0;
  int n_total = 0;

  logic [ROW_W-1:0]  mem [1024];
  logic [BEAT_W-1:0] q_data [$];
  bit                q_rl [$];
  bit                q_l [$];
  logic [AW-1:0]     q_addr [$];

  int done_cyc, first_v, stall_bad, n_done;
  bit rd_en_c1, busy_c1, timed_out;

  always #5 clk = ~clk;

  result_drain dut (
    .clk(clk), .rstn(rstn), .start(start),
    .base_addr(base_addr), .row_count(row_count),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row_last(m_row_last), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (sram_rd_en) begin
      sram_rd_data <= mem[sram_rd_addr];
      q_addr.push_back(sram_rd_addr);
    end
  end

  function automatic logic [BEAT_W-1:0] exp_beat(input int a, input int b);
    logic [BEAT_W-1:0] v;
    for (int j = 0; j < LPB; j++)
      v[j*PSB +: PSB] = PSB'(a * MS + b * LPB + j);
    return v;
  endfunction

  function automatic int sat_in(input int i);
    case (i % 4)
      0: return 300;
      1: return -300;
      2: return 127;
      default: return -129;
    endcase
  endfunction

  function automatic int sat_out(input int i);
`ifdef RESULT_DRAIN_SAT_EN
    case (i % 4)
      0: return 127;
      1: return -128;
      2: return 127;
      default: return -128;
    endcase
`else
    return sat_in(i);
`endif
  endfunction

  task automatic drain(input logic [AW-1:0] base, input logic [AW:0] cnt,
                       input bit rnd);
    bit stalled;
    logic [BEAT_W-1:0] held;
    q_data.delete(); q_rl.delete(); q_l.delete(); q_addr.delete();
    done_cyc = -1; first_v = -1; stall_bad = 0; n_done = 0;
    rd_en_c1 = 0; busy_c1 = 0; timed_out = 0;
    stalled = 0; held = '0;
    @(negedge clk);
    start = 1'b1; base_addr = base; row_count = cnt; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) @(negedge clk);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == 1) begin
        rd_en_c1 = sram_rd_en;
        busy_c1  = busy;
      end
      if (stalled && (!m_valid || m_data !== held)) stall_bad++;
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_rl.push_back(m_row_last);
        q_l.push_back(m_last);
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    m_ready = 1'b0;
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({m_valid, sram_rd_en, m_row_last, m_last, busy, done} !== 6'b0)
      $display("FAIL reset_ctrl got %b exp 000000",
               {m_valid, sram_rd_en, m_row_last, m_last, busy, done});
    else n_pass++;
    n_total++;
    if (sram_rd_addr !== '0)
      $display("FAIL reset_addr got %0d exp 0", sram_rd_addr);
    else n_pass++;
    n_total++;
    if (m_data !== '0) $display("FAIL reset_data got %h exp 0", m_data);
    else n_pass++;
    rstn = 1'b1;
  endtask

  task automatic test_in_order();
    drain(10'd0, 11'd4, 1'b0);
    n_total++;
    if (timed_out) $display("FAIL inorder_timeout got none exp done");
    else n_pass++;
    n_total++;
    if (rd_en_c1 !== 1'b1 || busy_c1 !== 1'b1)
      $display("FAIL inorder_t1 got rd_en=%b busy=%b exp 1 1", rd_en_c1, busy_c1);
    else n_pass++;
    n_total++;
    if (first_v != 3) $display("FAIL inorder_first_valid got %0d exp 3", first_v);
    else n_pass++;
    n_total++;
    if (done_cyc != 41) $display("FAIL inorder_done_cycle got %0d exp 41", done_cyc);
    else n_pass++;
    n_total++;
    if (n_done != 1) $display("FAIL inorder_done_count got %0d exp 1", n_done);
    else n_pass++;
    n_total++;
    if (q_data.size() != 32) $display("FAIL inorder_beats got %0d exp 32", q_data.size());
    else n_pass++;
    for (int k = 0; k < q_data.size() && k < 32; k++) begin
      n_total++;
      if (q_data[k] !== exp_beat(k / 8, k % 8))
        $display("FAIL inorder_beat%0d got %h exp %h", k, q_data[k], exp_beat(k / 8, k % 8));
      else n_pass++;
      n_total++;
      if (q_rl[k] !== (k % 8 == 7) || q_l[k] !== (k == 31))
        $display("FAIL inorder_last%0d got rl=%b l=%b exp %b %b",
                 k, q_rl[k], q_l[k], k % 8 == 7, k == 31);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    drain(10'd0, 11'd4, 1'b1);
    n_total++;
    if (timed_out) $display("FAIL bp_timeout got none exp done");
    else n_pass++;
    n_total++;
    if (stall_bad != 0) $display("FAIL bp_stall_stable got %0d exp 0", stall_bad);
    else n_pass++;
    n_total++;
    if (q_data.size() != 32) $display("FAIL bp_beats got %0d exp 32", q_data.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < q_data.size() && k < 32; k++)
      if (q_data[k] !== exp_beat(k / 8, k % 8) || q_l[k] !== (k == 31)) bad++;
    n_total++;
    if (bad != 0) $display("FAIL bp_sequence got %0d bad exp 0", bad);
    else n_pass++;
    n_total++;
    if (n_done != 1) $display("FAIL bp_done_count got %0d exp 1", n_done);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drain(10'd1022, 11'd4, 1'b0);
    n_total++;
    if (q_addr.size() != 4) $display("FAIL wrap_reads got %0d exp 4", q_addr.size());
    else n_pass++;
    n_total++;
    if (q_addr.size() == 4 &&
        (q_addr[0] !== 10'd1022 || q_addr[1] !== 10'd1023 ||
         q_addr[2] !== 10'd0 || q_addr[3] !== 10'd1))
      $display("FAIL wrap_order got %0d %0d %0d %0d exp 1022 1023 0 1",
               q_addr[0], q_addr[1], q_addr[2], q_addr[3]);
    else if (q_addr.size() == 4) n_pass++;
    n_total++;
    if (q_data.size() != 32 || q_data[16] !== exp_beat(0, 0))
      $display("FAIL wrap_row2_beat0 got %0d beats exp 32 from row 0", q_data.size());
    else n_pass++;
  endtask

  task automatic test_zero_rows();
    drain(10'd5, 11'd0, 1'b0);
    n_total++;
    if (done_cyc != 1) $display("FAIL zero_done_cycle got %0d exp 1", done_cyc);
    else n_pass++;
    n_total++;
    if (q_addr.size() != 0 || first_v != -1)
      $display("FAIL zero_activity got reads=%0d valid_at=%0d exp 0 -1",
               q_addr.size(), first_v);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dseen;
    dseen = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 10'd0; row_count = 11'd4; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 25; c++) @(negedge clk);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== exp_beat(2, 2))
      $display("FAIL abort_pre got v=%b %h exp 1 %h", m_valid, m_data, exp_beat(2, 2));
    else n_pass++;
    rstn = 1'b0;
    @(negedge clk);
    n_total++;
    if ({m_valid, sram_rd_en, m_row_last, m_last, busy, done} !== 6'b0 ||
        m_data !== '0 || sram_rd_addr !== '0)
      $display("FAIL abort_outputs got ctl=%b addr=%0d exp zeros",
               {m_valid, sram_rd_en, m_row_last, m_last, busy, done}, sram_rd_addr);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    n_total++;
    if (dseen != 0) $display("FAIL abort_no_done got %0d exp 0", dseen);
    else n_pass++;
    drain(10'd2, 11'd1, 1'b0);
    n_total++;
    if (q_addr.size() != 1 || q_addr[0] !== 10'd2)
      $display("FAIL abort_restart_addr got %0d reads exp addr 2", q_addr.size());
    else n_pass++;
    n_total++;
    if (q_data.size() != 8 || q_data[0] !== exp_beat(2, 0) || done_cyc != 11)
      $display("FAIL abort_restart got %0d beats done@%0d exp 8 11",
               q_data.size(), done_cyc);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int bad;
    logic [BEAT_W-1:0] e;
    drain(10'(SATROW), 11'd1, 1'b0);
    n_total++;
    if (q_data.size() != 8) $display("FAIL sat_beats got %0d exp 8", q_data.size());
    else n_pass++;
    for (int j = 0; j < LPB; j++) e[j*PSB +: PSB] = PSB'(sat_out(j));
    n_total++;
    if (q_data.size() < 1 || q_data[0] !== e)
      $display("FAIL sat_beat0 got %h exp %h", q_data.size() ? q_data[0] : '0, e);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < q_data.size() && k < 8; k++) begin
      for (int j = 0; j < LPB; j++) e[j*PSB +: PSB] = PSB'(sat_out(k * LPB + j));
      if (q_data[k] !== e) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL sat_all_beats got %0d bad exp 0", bad);
    else n_pass++;
  endtask

  initial begin
    for (int r = 0; r < 1024; r++)
      for (int i = 0; i < MS; i++)
        mem[r][i*PSB +: PSB] = PSB'(r * MS + i);
    for (int i = 0; i < MS; i++)
      mem[SATROW][i*PSB +: PSB] = PSB'(sat_in(i));
    test_reset();
    test_in_order();
    test_backpressure();
    test_wrap();
    test_zero_rows();
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
